// File: rtl/graph_edge_loader.sv
// Edge-stream loader for the serial PageRank engine: builds the
// partitioned adjacency tables and counts dangling nodes.
module graph_edge_loader #(
    parameter int NUM_PARTITIONS      = 1,
    parameter int NODES_PER_PARTITION = 4,
    parameter int MAX_DEGREE          = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        edge_valid,
    output logic        edge_ready,
    input  logic [31:0] edge_src,
    input  logic [31:0] edge_dst,
    input  logic        edge_last,
    output logic [31:0] source_id  [NUM_PARTITIONS][NODES_PER_PARTITION],
    output logic [31:0] out_degree [NUM_PARTITIONS][NODES_PER_PARTITION],
    output logic [31:0] dest_id    [NUM_PARTITIONS][NODES_PER_PARTITION][MAX_DEGREE],
    output logic [31:0] edge_count,
    output logic [31:0] dangling_count,
    output logic        err_range,
    output logic        err_overflow,
    output logic        graph_valid
);

    localparam int N  = NUM_PARTITIONS * NODES_PER_PARTITION;
    localparam int PW = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1;
    localparam int SW = (NODES_PER_PARTITION > 1) ? $clog2(NODES_PER_PARTITION) : 1;
    localparam int DW = (MAX_DEGREE > 1) ? $clog2(MAX_DEGREE) : 1;

    localparam logic [31:0] N32   = 32'(N);
    localparam logic [31:0] NPP32 = 32'(NODES_PER_PARTITION);
    localparam logic [31:0] MAXD  = 32'(MAX_DEGREE);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t      state;
    logic [31:0] scan_k;

    logic [PW-1:0] src_p;
    logic [SW-1:0] src_s;
    logic [PW-1:0] scan_p;
    logic [SW-1:0] scan_s;
    logic [31:0]   src_deg;
    logic [DW-1:0] src_slot;
    logic          beat_bad;
    logic          beat;
    logic          clear;

    for (genvar p = 0; p < NUM_PARTITIONS; p++) begin : g_part
        for (genvar s = 0; s < NODES_PER_PARTITION; s++) begin : g_slot
            assign source_id[p][s] = 32'(p * NODES_PER_PARTITION + s);
        end
    end

    assign src_p    = PW'(edge_src / NPP32);
    assign src_s    = SW'(edge_src % NPP32);
    assign scan_p   = PW'(scan_k / NPP32);
    assign scan_s   = SW'(scan_k % NPP32);
    assign src_deg  = out_degree[src_p][src_s];
    assign src_slot = DW'(src_deg);
    assign beat_bad = (edge_src >= N32) || (edge_dst >= N32);
    assign beat     = edge_valid && edge_ready;
    assign clear    = start && (state == IDLE || state == DONE);

    always_ff @(posedge clock) begin
        // Reset and a fresh start share the same table wipe.
        if (reset || clear) begin
            for (int p = 0; p < NUM_PARTITIONS; p++) begin
                for (int s = 0; s < NODES_PER_PARTITION; s++) begin
                    out_degree[p][s] <= '0;
                    for (int d = 0; d < MAX_DEGREE; d++) begin
                        dest_id[p][s][d] <= '0;
                    end
                end
            end
            edge_count     <= '0;
            dangling_count <= '0;
            err_range      <= 1'b0;
            err_overflow   <= 1'b0;
            graph_valid    <= 1'b0;
            scan_k         <= '0;
        end

        if (reset) begin
            state      <= IDLE;
            edge_ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        edge_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (beat_bad) begin
                            err_range <= 1'b1;
                        end else if (src_deg == MAXD) begin
                            err_overflow <= 1'b1;
                        end else begin
                            dest_id[src_p][src_s][src_slot] <= edge_dst;
                            out_degree[src_p][src_s] <= src_deg + 32'd1;
                            edge_count <= edge_count + 32'd1;
                        end
                        if (edge_last) begin
                            state      <= SCAN;
                            edge_ready <= 1'b0;
                            scan_k     <= '0;
                        end
                    end
                end
                SCAN: begin
                    dangling_count <= dangling_count
                        + 32'(out_degree[scan_p][scan_s] == '0);
                    scan_k <= scan_k + 32'd1;
                    if (scan_k == N32 - 32'd1) begin
                        state       <= DONE;
                        graph_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_graph_edge_loader.sv
// Bench for graph_edge_loader: directed graphs plus random edge
// streams checked against a per-node adjacency-list model.
module tb_graph_edge_loader;

    localparam int NP  = 1;
    localparam int NPP = 4;
    localparam int MD  = 3;
    localparam int N   = NP * NPP;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        edge_valid;
    logic        edge_ready;
    logic [31:0] edge_src;
    logic [31:0] edge_dst;
    logic        edge_last;
    logic [31:0] source_id  [NP][NPP];
    logic [31:0] out_degree [NP][NPP];
    logic [31:0] dest_id    [NP][NPP][MD];
    logic [31:0] edge_count;
    logic [31:0] dangling_count;
    logic        err_range;
    logic        err_overflow;
    logic        graph_valid;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned adj [N][$];
    bit          m_range;
    bit          m_ovf;
    int unsigned m_count;

    int unsigned qs [$];
    int unsigned qd [$];

    always #5 clock = ~clock;

    graph_edge_loader #(
        .NUM_PARTITIONS      (NP),
        .NODES_PER_PARTITION (NPP),
        .MAX_DEGREE          (MD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .edge_valid     (edge_valid),
        .edge_ready     (edge_ready),
        .edge_src       (edge_src),
        .edge_dst       (edge_dst),
        .edge_last      (edge_last),
        .source_id      (source_id),
        .out_degree     (out_degree),
        .dest_id        (dest_id),
        .edge_count     (edge_count),
        .dangling_count (dangling_count),
        .err_range      (err_range),
        .err_overflow   (err_overflow),
        .graph_valid    (graph_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < N; n++) adj[n].delete();
        m_range = 1'b0;
        m_ovf   = 1'b0;
        m_count = 0;
    endtask

    task automatic model_edge(input logic [31:0] s, input logic [31:0] d);
        if (s >= N || d >= N) m_range = 1'b1;
        else if (adj[s].size() == MD) m_ovf = 1'b1;
        else begin
            adj[s].push_back(d);
            m_count++;
        end
    endtask

    task automatic check_tables(input string tag, input bit gv);
        int dang = 0;
        for (int n = 0; n < N; n++) begin
            chk({tag, "_deg"}, out_degree[n / NPP][n % NPP], adj[n].size());
            for (int j = 0; j < MD; j++) begin
                chk({tag, "_dest"}, dest_id[n / NPP][n % NPP][j],
                    (j < adj[n].size()) ? adj[n][j] : 0);
            end
            if (adj[n].size() == 0) dang++;
        end
        chk({tag, "_count"}, edge_count, m_count);
        chk({tag, "_dangling"}, dangling_count, gv ? dang : 0);
        chk({tag, "_err_range"}, 32'(err_range), 32'(m_range));
        chk({tag, "_err_ovf"}, 32'(err_overflow), 32'(m_ovf));
        chk({tag, "_gv"}, 32'(graph_valid), 32'(gv));
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        model_clear();
        chk("start_ready", 32'(edge_ready), 32'd1);
        chk("start_gv", 32'(graph_valid), 32'd0);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send(input logic [31:0] s, input logic [31:0] d,
                        input bit last, input int gap, input bit poke);
        int  budget = 0;
        bit  rdy;
        while ($urandom_range(99) < gap) begin
            edge_valid = 1'b0;
            @(negedge clock);
        end
        edge_valid = 1'b1;
        edge_src   = s;
        edge_dst   = d;
        edge_last  = last;
        while (!edge_ready && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        rdy = edge_ready;
        chk("hs_ready", 32'(rdy), 32'd1);
        @(posedge clock);
        if (rdy) model_edge(s, d);
        if (last) begin
            #1;
            edge_valid = 1'b0;
            edge_last  = 1'b0;
            chk("ready_drop", 32'(edge_ready), 32'd0);
            for (int i = 1; i <= N; i++) begin
                if (poke && i == 1) start = 1'b1;
                @(posedge clock);
                #1;
                start = 1'b0;
                chk("gv_latency", 32'(graph_valid), 32'(i == N));
            end
        end
        @(negedge clock);
    endtask

    task automatic load_queue(input int gap, input bit poke);
        for (int i = 0; i < qs.size(); i++) begin
            send(qs[i], qd[i], i == qs.size() - 1, gap, poke);
        end
    endtask

    function automatic logic [31:0] pick();
        int unsigned r = $urandom_range(0, 19);
        if (r == 0) return $urandom;
        if (r == 1) return N;
        return $urandom_range(0, N - 1);
    endfunction

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        edge_valid = 1'b0;
        edge_src   = '0;
        edge_dst   = '0;
        edge_last  = 1'b0;
        model_clear();
        repeat (3) @(negedge clock);

        for (int n = 0; n < N; n++) begin
            chk("source_id_rst", source_id[n / NPP][n % NPP], n);
        end
        chk("rst_ready", 32'(edge_ready), 32'd0);
        check_tables("rst", 1'b0);

        reset = 1'b0;
        edge_valid = 1'b1;
        edge_src   = 32'd1;
        edge_dst   = 32'd2;
        repeat (3) @(negedge clock);
        chk("idle_ready", 32'(edge_ready), 32'd0);
        check_tables("idle_valid", 1'b0);
        edge_valid = 1'b0;

        // Reference graph, valid held high.
        qs = '{0, 0, 1, 2, 2, 2, 3};
        qd = '{1, 2, 3, 0, 1, 3, 2};
        pulse_start();
        check_tables("clr1", 1'b0);
        load_queue(0, 1'b0);
        check_tables("ref", 1'b1);
        chk("ref_deg2", out_degree[0][2], 32'd3);

        // Same graph with valid gaps.
        pulse_start();
        check_tables("clr2", 1'b0);
        load_queue(50, 1'b0);
        check_tables("gaps", 1'b1);

        // Degree overflow on node 0.
        qs = '{0, 0, 0, 0};
        qd = '{1, 2, 3, 0};
        pulse_start();
        load_queue(0, 1'b0);
        check_tables("ovf", 1'b1);

        // Out-of-range ids, last on a dropped beat.
        qs = '{5, 1};
        qd = '{1, 9};
        pulse_start();
        load_queue(0, 1'b0);
        check_tables("range", 1'b1);

        // Reset part-way through a load.
        pulse_start();
        send(32'd0, 32'd1, 1'b0, 0, 1'b0);
        send(32'd1, 32'd2, 1'b0, 0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        chk("midrst_ready", 32'(edge_ready), 32'd0);
        check_tables("midrst", 1'b0);
        pulse_start();
        send(32'd3, 32'd0, 1'b1, 0, 1'b0);
        check_tables("after_rst", 1'b1);

        // Restart from DONE, with a start poked during SCAN.
        pulse_start();
        check_tables("restart", 1'b0);
        qs = '{2, 2, 1};
        qd = '{2, 2, 0};
        load_queue(0, 1'b1);
        check_tables("scan_start", 1'b1);

        for (int it = 0; it < 20; it++) begin
            int len = $urandom_range(1, 12);
            pulse_start();
            for (int i = 0; i < len; i++) begin
                send(pick(), pick(), i == len - 1, 50, it % 4 == 0);
            end
            check_tables("rnd", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
